fifo_write_arbiter: RTL and testbench

//   Round-robin arbiter sharing the single write port of a simple_fifo among NUM_REQ producers.

---
 rtl/fifo_write_arbiter_if.sv | 28 ++
 rtl/fifo_write_arbiter.sv | 98 +++++++++
 tb/tb_fifo_write_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO side bundle of the round-robin FIFO write arbiter.
//   master : environment side (producers + FIFO) drives req, req_data, fifo_full
//   slave  : arbiter side drives ack, fifo_wr_en, fifo_wr_data, busy, owner
interface fifo_write_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          busy;
  logic [OW-1:0]                 owner;

  modport master (
    output req, req_data, fifo_full,
    input  ack, fifo_wr_en, fifo_wr_data, busy, owner
  );

  modport slave (
    input  req, req_data, fifo_full,
    output ack, fifo_wr_en, fifo_wr_data, busy, owner
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant lasts up to MAX_BURST beats, then ownership rotates after one
// IDLE arbitration cycle.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave modport (req/req_data/fifo_full in; ack/fifo_wr_en/
//           fifo_wr_data/busy/owner out)
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                clk,
  input  logic                reset,
  fifo_write_arbiter_if.slave bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t          r_state;
  logic [OW-1:0]   r_owner;
  logic [BW-1:0]   r_beat_cnt;

  logic                  w_xfer;
  logic [OW-1:0]         w_pick;
  logic [NUM_REQ-1:0]    w_ack;
  logic [DATA_WIDTH-1:0] w_data;

  // Search owner+1, owner+2, ... owner+NUM_REQ (mod NUM_REQ). Scanning from
  // the far end and letting nearer hits overwrite gives the first requester.
  always_comb begin
    logic [OW-1:0] cand;
    w_pick = r_owner;
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      cand = OW'((32'(r_owner) + i) % NUM_REQ);
      if (bus.req[cand]) w_pick = cand;
    end
  end

  // Writes only happen in GRANT, so reset (state=IDLE) gates them at once.
  assign w_xfer = (r_state == GRANT) && bus.req[r_owner] && !bus.fifo_full;

  always_comb begin
    w_ack          = '0;
    w_ack[r_owner] = w_xfer;
  end

  always_comb begin
    w_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_owner == OW'(i)) w_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= OW'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_owner    <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          if (!bus.req[r_owner]) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
          end else if (!bus.fifo_full) begin
            if (r_beat_cnt == BW'(MAX_BURST - 1)) begin
              r_state    <= IDLE;
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + BW'(1);
            end
          end
          // req held with FIFO full: stall, state and beat count unchanged
        end
        default: begin
          r_state    <= IDLE;
          r_beat_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.ack          = w_ack;
  assign bus.fifo_wr_en   = w_xfer;
  assign bus.fifo_wr_data = w_data;
  assign bus.busy         = (r_state == GRANT);
  assign bus.owner        = r_owner;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();

  fifo_write_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    int unsigned prod;
    logic [7:0]  data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  fifo_q[$];
  logic [7:0]  pmem [4][32];
  int unsigned phead [4];
  int unsigned ptail [4];
  int unsigned ack_cnt [4];
  int unsigned n_chk, n_pass, n_fail, wr_cnt;
  logic        force_full, rd_req;
  logic [7:0]  rd_word;
  logic [31:0] wr_trace, busy_trace;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic add_word(input int unsigned p, input logic [7:0] d);
    pmem[p][ptail[p]] = d;
    ptail[p]++;
  endtask

  task automatic expect_wr(input int unsigned p, input logic [7:0] d);
    exp_t e;
    e.prod = p;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Producers present the head of their word list; FIFO full is the model's
  // occupancy or a forced override.
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (phead[i] < ptail[i]) begin
        bus.req[i]            = 1'b1;
        bus.req_data[i*8 +: 8] = pmem[i][phead[i]];
      end else begin
        bus.req[i]            = 1'b0;
        bus.req_data[i*8 +: 8] = 8'h00;
      end
    end
    bus.fifo_full = force_full || (fifo_q.size() >= 16);
  endtask

  // Sample the current cycle, update models, advance one clock, re-drive.
  task automatic step();
    exp_t e;
    logic [3:0] onehot;
    wr_trace   = {wr_trace[30:0], bus.fifo_wr_en};
    busy_trace = {busy_trace[30:0], bus.busy};
    check("ack_iff_wren", 32'(|bus.ack), 32'(bus.fifo_wr_en));
    if (bus.fifo_wr_en) begin
      wr_cnt++;
      check("no_overrun", 32'(fifo_q.size() < 16), 32'd1);
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e      = exp_q.pop_front();
        onehot = 4'b0001 << e.prod;
        check("wr_data", 32'(bus.fifo_wr_data), 32'(e.data));
        check("ack_onehot", 32'(bus.ack), 32'(onehot));
      end
      fifo_q.push_back(bus.fifo_wr_data);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.ack[i]) begin
        ack_cnt[i]++;
        if (phead[i] < ptail[i]) phead[i]++;
      end
    end
    if (rd_req && fifo_q.size() > 0) rd_word = fifo_q.pop_front();
    @(posedge clk);
    #1;
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      phead[i]   = 0;
      ptail[i]   = 0;
      ack_cnt[i] = 0;
    end
    exp_q.delete();
    fifo_q.delete();
    force_full = 1'b0;
    rd_req     = 1'b0;
    drive();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    wr_trace   = '0;
    busy_trace = '0;
    wr_cnt     = 0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; wr_cnt = 0;
    force_full = 1'b0; rd_req = 1'b0; rd_word = 8'h00;
    wr_trace = '0; busy_trace = '0;
    for (int i = 0; i < 4; i++) begin
      phead[i] = 0; ptail[i] = 0; ack_cnt[i] = 0;
    end

    // Reset state with every producer requesting: outputs stay gated.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) add_word(i, 8'hE0 + 8'(i));
    drive();
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_owner", 32'(bus.owner), 32'd3);
    check("rst_wren", 32'(bus.fifo_wr_en), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);

    // Single producer, 6 words: burst of 4, one IDLE, then 2.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      add_word(0, 8'h10 + 8'(k));
      expect_wr(0, 8'h10 + 8'(k));
    end
    drive(); #1;
    repeat (9) step();
    check("t1_wr_trace", 32'(wr_trace[8:0]), 32'(9'b011110110));
    check("t1_sb_empty", exp_q.size(), 0);
    check("t1_fifo_level", fifo_q.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < fifo_q.size()) check("t1_readback", 32'(fifo_q[k]), 32'h10 + 32'(k));
    end

    // All four streaming: order 0,1,2,3,0 with 4-beat bursts.
    do_reset();
    rd_req = 1'b1;
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 8; k++) add_word(p, 8'h40 + 8'(p*16 + k));
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < 4; k++) expect_wr(b % 4, 8'h40 + 8'((b % 4)*16 + (b/4)*4 + k));
    drive(); #1;
    repeat (25) step();
    check("t2_wr_trace", 32'(wr_trace[24:0]), 32'(25'b0111101111011110111101111));
    check("t2_sb_empty", exp_q.size(), 0);
    check("t2_acks_p0", ack_cnt[0], 8);
    check("t2_acks_p3", ack_cnt[3], 4);

    // Producer 2 stalled by full for 3 cycles after its first beat.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      add_word(2, 8'h60 + 8'(k));
      expect_wr(2, 8'h60 + 8'(k));
    end
    drive(); #1;
    for (int k = 0; k < 12; k++) begin
      force_full = (k >= 1 && k <= 3);
      step();
    end
    check("t3_wr_trace", 32'(wr_trace[11:0]), 32'(12'b010001110110));
    check("t3_busy_trace", 32'(busy_trace[11:0]), 32'(12'b011111110111));
    check("t3_sb_empty", exp_q.size(), 0);
    check("t3_acks_p2", ack_cnt[2], 6);

    // Producer 1 drops after 2 beats; producer 3 follows.
    do_reset();
    add_word(1, 8'h71); add_word(1, 8'h72);
    add_word(3, 8'h91); add_word(3, 8'h92);
    expect_wr(1, 8'h71); expect_wr(1, 8'h72);
    expect_wr(3, 8'h91); expect_wr(3, 8'h92);
    drive(); #1;
    repeat (8) step();
    check("t4_wr_trace", 32'(wr_trace[7:0]), 32'(8'b01100110));
    check("t4_busy_trace", 32'(busy_trace[7:0]), 32'(8'b01110111));
    check("t4_acks_p1", ack_cnt[1], 2);
    check("t4_acks_p3", ack_cnt[3], 2);

    // Reset at beat 2 aborts the write immediately.
    do_reset();
    for (int k = 0; k < 4; k++) add_word(0, 8'hA0 + 8'(k));
    expect_wr(0, 8'hA0);
    drive(); #1;
    repeat (2) step();
    check("t5_pre_wren", 32'(bus.fifo_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_wren", 32'(bus.fifo_wr_en), 32'd0);
    check("t5_rst_ack", 32'(bus.ack), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_owner", 32'(bus.owner), 32'd3);
    check("t5_sb_empty", exp_q.size(), 0);
    check("t5_fifo_level", fifo_q.size(), 1);
    do_reset();
    add_word(1, 8'hB1); add_word(3, 8'hB3);
    expect_wr(1, 8'hB1); expect_wr(3, 8'hB3);
    drive(); #1;
    repeat (6) step();
    check("t5_wr_trace", 32'(wr_trace[5:0]), 32'(6'b010010));
    check("t5_post_sb_empty", exp_q.size(), 0);

    // Fill FIFO to 16, stall, one read lets exactly one write through.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      add_word(0, 8'hC0 + 8'(k));
      add_word(2, 8'hD0 + 8'(k));
    end
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 4; k++)
        expect_wr((b % 2) * 2, ((b % 2) == 0 ? 8'hC0 : 8'hD0) + 8'((b/2)*4 + k));
    expect_wr(0, 8'hC8);
    drive(); #1;
    repeat (25) step();
    check("t6_wr_trace", 32'(wr_trace[24:0]), 32'(25'b0111101111011110111100000));
    check("t6_fifo_level_full", fifo_q.size(), 16);
    check("t6_stall_busy", 32'(bus.busy), 32'd1);
    check("t6_stall_owner", 32'(bus.owner), 32'd0);
    wr_cnt = 0;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    check("t6_read_word", 32'(rd_word), 32'hC0);
    repeat (5) step();
    check("t6_one_write", wr_cnt, 1);
    check("t6_fifo_level_refull", fifo_q.size(), 16);
    check("t6_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
